// File: rtl/game2048_pkg.sv
// Shared constants and encodings for the 2048 game: direction codes,
// the button-input FSM state type and the game status encoding.
package game2048_pkg;

    localparam logic [3:0] DIR_NONE   = 4'b0000;
    localparam logic [3:0] DIR_TOP    = 4'b0001;
    localparam logic [3:0] DIR_BOTTOM = 4'b0010;
    localparam logic [3:0] DIR_LEFT   = 4'b0100;
    localparam logic [3:0] DIR_RIGHT  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DEBOUNCE = 2'b01,
        ISSUE    = 2'b10,
        HOLD     = 2'b11
    } dir_state_t;

    typedef enum logic [1:0] {
        GS_NOT_PLAYING = 2'b00,
        GS_PLAYING     = 2'b01,
        GS_WIN         = 2'b10,
        GS_LOSE        = 2'b11
    } game_state_t;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for asynchronous button pins; flops reset to the
// inactive (zero) level.
module btn_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking so both stages shift on the same edge; blocking
    // assignments here would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/direction_input.sv
// Debounced one-hot direction request from four push buttons, held until
// acknowledged. Define DIRECTION_AUTO_REPEAT_EN to re-issue a held direction.
module direction_input
    import game2048_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 12500000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       dir_ack,
    output logic [3:0] direction,
    output logic       multi_press
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                               : REPEAT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t CNT_SAT  = cnt_t'(CNT_MAX);
`ifdef DIRECTION_AUTO_REPEAT_EN
    localparam cnt_t REP_LAST = cnt_t'(REPEAT_CYCLES - 1);
`endif

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == CNT_SAT) ? c : c + cnt_t'(1);
    endfunction

    logic [3:0] btn_level;
    logic [3:0] sync;
    logic       sync_zero;

    assign btn_level = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

    btn_sync #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_level),
        .q   (sync)
    );

    assign sync_zero = (sync == 4'b0000);

    dir_state_t state_q, state_d;
    logic [3:0] cand_q, cand_d;
    cnt_t       cnt_q, cnt_d;
    cnt_t       run;
    logic [3:0] dir_q, dir_d;
    logic       mp_q, mp_d;
    logic       zero_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cand_q  <= DIR_NONE;
            cnt_q   <= '0;
            dir_q   <= DIR_NONE;
            mp_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mp_q    <= mp_d;
            zero_q  <= sync_zero;
        end
    end

    // HOLD shares one counter between the release run and the repeat run;
    // a change of category since last cycle restarts the run from zero.
    assign run = (zero_q == sync_zero) ? cnt_q : '0;

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        dir_d   = DIR_NONE;
        mp_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!sync_zero) begin
                    cand_d  = sync;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (sync != cand_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d = '0;
                    if (is_one_hot(cand_q)) begin
                        dir_d   = cand_q;
                        state_d = ISSUE;
                    end else begin
                        mp_d    = 1'b1;
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            ISSUE: begin
                if (dir_ack) begin
                    state_d = HOLD;
`ifdef DIRECTION_AUTO_REPEAT_EN
                    // The ack cycle itself counts toward the next repeat.
                    cnt_d = (sync == cand_q) ? cnt_t'(1) : '0;
`else
                    cnt_d = '0;
`endif
                end else begin
                    dir_d = cand_q;
                end
            end

            HOLD: begin
                if (sync_zero) begin
                    if (run == DEB_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = sat_inc(run);
                    end
`ifdef DIRECTION_AUTO_REPEAT_EN
                end else if ((sync == cand_q) && is_one_hot(cand_q)) begin
                    if (run == REP_LAST) begin
                        cnt_d   = '0;
                        dir_d   = cand_q;
                        state_d = ISSUE;
                    end else begin
                        cnt_d = sat_inc(run);
                    end
`endif
                end else begin
                    cnt_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign direction   = dir_q;
    assign multi_press = mp_q;

endmodule

// File: tb/tb_direction_input.sv
// Bench for direction_input with short debounce/repeat times: run-length
// stimulus table plus hand-written reset sequence, scoreboard checked per cycle.
module tb_direction_input;

    localparam int D = 4;
    localparam int R = 16;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic       dir_ack;
    logic [3:0] direction;
    logic       multi_press;

    direction_input #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .dir_ack     (dir_ack),
        .direction   (direction),
        .multi_press (multi_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        logic       ack;
        logic [3:0] dir;
        logic       mp;
        int         n;
        string      tag;
    } seg_t;

    typedef struct {
        logic [3:0] dir;
        logic       mp;
        string      tag;
    } exp_t;

    seg_t tbl[$];
    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
    task automatic step(input logic [3:0] b, input logic a, input logic [3:0] ed,
                        input logic em, input string tag);
        exp_t e;
        btn_raw = b;
        dir_ack = a;
        exp_q.push_back('{dir: ed, mp: em, tag: tag});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".direction"}, direction, e.dir);
        check({e.tag, ".multi_press"}, {3'b000, multi_press}, {3'b000, e.mp});
    endtask

    function automatic void add(input logic [3:0] b, input logic a, input logic [3:0] d,
                                input logic m, input int n, input string tag);
        tbl.push_back('{btn: b, ack: a, dir: d, mp: m, n: n, tag: tag});
    endfunction

    initial begin
        rst     = 1'b0;
        btn_raw = 4'b1111;
        dir_ack = 1'b0;

        // idle settle
        add(4'b1111, 1'b0, 4'b0000, 1'b0, 4, "idle");
        // top steady, ack tied high: single-cycle pulse at edge D+3
        add(4'b1110, 1'b1, 4'b0000, 1'b0, D + 2, "top_wait");
        add(4'b1110, 1'b1, 4'b0001, 1'b0, 1,     "top_pulse");
        add(4'b1110, 1'b1, 4'b0000, 1'b0, 10,    "top_held");
        add(4'b1111, 1'b1, 4'b0000, 1'b0, 8,     "top_rel");
        // bounce every 2 cycles never survives debounce
        for (int i = 0; i < 5; i++) begin
            add(4'b1110, 1'b1, 4'b0000, 1'b0, 2, "bounce_on");
            add(4'b1111, 1'b1, 4'b0000, 1'b0, 2, "bounce_off");
        end
        add(4'b1111, 1'b1, 4'b0000, 1'b0, 6, "bounce_end");
        // top+left: multi_press pulse only, then left alone issues
        add(4'b1010, 1'b1, 4'b0000, 1'b0, D + 2, "multi_wait");
        add(4'b1010, 1'b1, 4'b0000, 1'b1, 1,     "multi_pulse");
        add(4'b1010, 1'b1, 4'b0000, 1'b0, 6,     "multi_held");
        add(4'b1111, 1'b1, 4'b0000, 1'b0, 8,     "multi_rel");
        add(4'b1011, 1'b1, 4'b0000, 1'b0, D + 2, "left_wait");
        add(4'b1011, 1'b1, 4'b0100, 1'b0, 1,     "left_pulse");
        add(4'b1011, 1'b1, 4'b0000, 1'b0, 3,     "left_held");
        add(4'b1111, 1'b1, 4'b0000, 1'b0, 8,     "left_rel");
        // left with no ack: request survives release until acked
        add(4'b1011, 1'b0, 4'b0000, 1'b0, D + 2, "pend_wait");
        add(4'b1011, 1'b0, 4'b0100, 1'b0, 4,     "pend_press");
        add(4'b1111, 1'b0, 4'b0100, 1'b0, 20,    "pend_released");
        add(4'b1111, 1'b1, 4'b0000, 1'b0, 1,     "pend_ack");
        add(4'b1111, 1'b0, 4'b0000, 1'b0, 6,     "pend_idle");
        // button added during HOLD must not issue
        add(4'b1110, 1'b1, 4'b0000, 1'b0, D + 2, "add_wait");
        add(4'b1110, 1'b1, 4'b0001, 1'b0, 1,     "add_pulse");
        add(4'b1110, 1'b1, 4'b0000, 1'b0, 3,     "add_held");
        add(4'b1010, 1'b1, 4'b0000, 1'b0, 8,     "add_second");
        add(4'b1111, 1'b1, 4'b0000, 1'b0, 8,     "add_rel");
`ifdef DIRECTION_AUTO_REPEAT_EN
        // bottom held with ack: pulses every R cycles, stop on release
        add(4'b1101, 1'b1, 4'b0000, 1'b0, D + 2, "rep_wait");
        add(4'b1101, 1'b1, 4'b0010, 1'b0, 1,     "rep_pulse0");
        add(4'b1101, 1'b1, 4'b0000, 1'b0, R - 1, "rep_gap0");
        add(4'b1101, 1'b1, 4'b0010, 1'b0, 1,     "rep_pulse1");
        add(4'b1101, 1'b1, 4'b0000, 1'b0, R - 1, "rep_gap1");
        add(4'b1101, 1'b1, 4'b0010, 1'b0, 1,     "rep_pulse2");
        add(4'b1101, 1'b1, 4'b0000, 1'b0, 5,     "rep_gap2");
        add(4'b1111, 1'b1, 4'b0000, 1'b0, 25,    "rep_rel");
`else
        // bottom held long with ack: exactly one pulse, no repeat
        add(4'b1101, 1'b1, 4'b0000, 1'b0, D + 2, "norep_wait");
        add(4'b1101, 1'b1, 4'b0010, 1'b0, 1,     "norep_pulse");
        add(4'b1101, 1'b1, 4'b0000, 1'b0, 40,    "norep_held");
        add(4'b1111, 1'b1, 4'b0000, 1'b0, 8,     "norep_rel");
`endif

        #12;
        check("reset.direction", direction, 4'b0000);
        check("reset.multi_press", {3'b000, multi_press}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[s]) begin
            for (int k = 0; k < tbl[s].n; k++)
                step(tbl[s].btn, tbl[s].ack, tbl[s].dir, tbl[s].mp, tbl[s].tag);
        end

        // reset while a request is pending drops it immediately
        for (int k = 0; k < D + 2; k++)
            step(4'b1110, 1'b0, 4'b0000, 1'b0, "rst_wait");
        step(4'b1110, 1'b0, 4'b0001, 1'b0, "rst_issue");
        step(4'b1110, 1'b0, 4'b0001, 1'b0, "rst_pending");
        #3;
        btn_raw = 4'b1111;
        rst     = 1'b0;
        #1;
        check("rst_mid.direction", direction, 4'b0000);
        check("rst_mid.multi_press", {3'b000, multi_press}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 15; k++)
            step(4'b1111, 1'b0, 4'b0000, 1'b0, "rst_after");
        // fresh press still works after reset
        for (int k = 0; k < D + 2; k++)
            step(4'b1110, 1'b1, 4'b0000, 1'b0, "fresh_wait");
        step(4'b1110, 1'b1, 4'b0001, 1'b0, "fresh_pulse");
        step(4'b1110, 1'b1, 4'b0000, 1'b0, "fresh_held");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
